// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: each channel yields a 50% square wave
// and a one-cycle tick every div+1 enabled cycles, with a runtime divisor write port.
module clk_div_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 26,
    parameter int DEFAULT_DIV = 24_999_999,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] en_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [WIDTH-1:0]    cfg_div_i,
    output logic [CHANNELS-1:0] out_o,
    output logic [CHANNELS-1:0] tick_o,
    output logic [WIDTH-1:0]    rd_div_o
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0]    div_q [CHANNELS];
    logic [WIDTH-1:0]    div_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [WIDTH-1:0]    rd_div_q, rd_div_d;

    always_comb begin
        div_d    = div_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        tick_d   = '0;
        rd_div_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // A write zeroes the count, so cnt can never run past div.
            if (cfg_we_i && (cfg_ch_i == CH_W'(i))) begin
                div_d[i] = cfg_div_i;
                cnt_d[i] = '0;
            end else if (en_i[i]) begin
                if (cnt_q[i] == div_q[i]) begin
                    cnt_d[i]  = '0;
                    out_d[i]  = ~out_q[i];
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
            // Out-of-range selects match no channel and read back as zero.
            if (cfg_ch_i == CH_W'(i)) begin
                rd_div_d = div_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                div_q[i] <= DEF_DIV;
                cnt_q[i] <= '0;
            end
            out_q    <= '0;
            tick_q   <= '0;
            rd_div_q <= '0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            tick_q   <= tick_d;
            rd_div_q <= rd_div_d;
        end
    end

    assign out_o    = out_q;
    assign tick_o   = tick_q;
    assign rd_div_o = rd_div_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: default 4-channel instance plus a 3-channel
// instance for the out-of-range channel select case.
module tb_clk_div_multi;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance (CHANNELS=4, WIDTH=26)
    logic        rst;
    logic [3:0]  en;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [25:0] cfg_div;
    logic [3:0]  out_w;
    logic [3:0]  tick_w;
    logic [25:0] rd_div_w;

    clk_div_multi dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .cfg_we_i  (cfg_we),
        .cfg_ch_i  (cfg_ch),
        .cfg_div_i (cfg_div),
        .out_o     (out_w),
        .tick_o    (tick_w),
        .rd_div_o  (rd_div_w)
    );

    // Non-power-of-two instance
    logic        rst3;
    logic [2:0]  en3;
    logic        we3;
    logic [1:0]  ch3;
    logic [7:0]  div3;
    logic [2:0]  out3_w;
    logic [2:0]  tick3_w;
    logic [7:0]  rd3_w;

    clk_div_multi #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DIV(5)) dut3 (
        .clk_i     (clk),
        .rst_i     (rst3),
        .en_i      (en3),
        .cfg_we_i  (we3),
        .cfg_ch_i  (ch3),
        .cfg_div_i (div3),
        .out_o     (out3_w),
        .tick_o    (tick3_w),
        .rd_div_o  (rd3_w)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        rst3 = 1'b1; en3 = '0; we3 = 1'b0; ch3 = '0; div3 = '0;

        // Reset values
        cyc(); cyc();
        chk("rst_out", 32'(out_w), 32'h0);
        chk("rst_tick", 32'(tick_w), 32'h0);
        chk("rst_rd", 32'(rd_div_w), 32'h0);
        rst = 1'b0;
        cyc();
        chk("rst_rd_default", 32'(rd_div_w), 32'd24_999_999);
        chk("rst_out_idle", 32'(out_w), 32'h0);
        chk("rst_tick_idle", 32'(tick_w), 32'h0);

        // Basic divide: ch0 div=3 -> tick every 4, out period 8
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 26'd3; en[0] = 1'b1;
        cyc();
        cfg_we = 1'b0;
        chk("basic_rd_old", 32'(rd_div_w), 32'd24_999_999);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 1) chk("basic_rd_new", 32'(rd_div_w), 32'd3);
            chk($sformatf("basic_tick_k%0d", k), 32'(tick_w[0]), 32'((k % 4) == 0));
            chk($sformatf("basic_out_k%0d", k), 32'(out_w[0]), 32'(((k / 4) % 2) == 1));
        end

        // div=0 on ch1: tick stuck high, out toggles every cycle; then freeze
        en[0] = 1'b0;
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 26'd0; en[1] = 1'b1;
        cyc();
        cfg_we = 1'b0;
        chk("div0_tick_write", 32'(tick_w[1]), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("div0_tick_k%0d", k), 32'(tick_w[1]), 32'h1);
            chk($sformatf("div0_out_k%0d", k), 32'(out_w[1]), 32'(k & 1));
        end
        en[1] = 1'b0;
        cyc();
        chk("div0_off_tick", 32'(tick_w[1]), 32'h0);
        chk("div0_off_out", 32'(out_w[1]), 32'h1);
        cyc();
        chk("div0_hold_out", 32'(out_w[1]), 32'h1);
        chk("ch0_held_out", 32'(out_w[0]), 32'h1);

        // Write colliding with terminal count on ch2; ch0 runs alongside
        en[0] = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 26'd3;
        cyc();
        en[2] = 1'b1; cfg_ch = 2'd2; cfg_div = 26'd5;
        cyc();
        for (int e = 1; e <= 12; e++) begin
            if (e == 6) begin
                cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 26'd2;
            end else begin
                cfg_we = 1'b0;
            end
            cyc();
            chk($sformatf("coll_tick2_e%0d", e), 32'(tick_w[2]), 32'((e == 9) || (e == 12)));
            chk($sformatf("coll_out2_e%0d", e), 32'(out_w[2]), 32'((e >= 9) && (e < 12)));
            chk($sformatf("coll_tick0_e%0d", e), 32'(tick_w[0]), 32'(((e + 1) % 4) == 0));
            chk($sformatf("coll_out0_e%0d", e), 32'(out_w[0]), 32'(1 ^ (((e + 1) / 4) & 1)));
        end

        // Enable gating on ch3 div=9: pause at cnt=4 for 7 cycles
        en = 4'b0000;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 26'd9; en[3] = 1'b1;
        cyc();
        cfg_we = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("gate_pre_tick_k%0d", k), 32'(tick_w[3]), 32'h0);
        end
        en[3] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk($sformatf("gate_off_tick_k%0d", k), 32'(tick_w[3]), 32'h0);
        end
        en[3] = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cyc();
            chk($sformatf("gate_tick_j%0d", j), 32'(tick_w[3]), 32'((j == 6) || (j == 16)));
            chk($sformatf("gate_out_j%0d", j), 32'(out_w[3]), 32'((j >= 6) && (j < 16)));
        end

        // Reset during a write with all channels running
        en = 4'b1111;
        cyc(); cyc(); cyc();
        rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 26'd100;
        cyc();
        chk("mid_rst_out", 32'(out_w), 32'h0);
        chk("mid_rst_tick", 32'(tick_w), 32'h0);
        rst = 1'b0; cfg_we = 1'b0; en = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            cfg_ch = 2'(c);
            cyc();
            chk($sformatf("mid_rst_rd_ch%0d", c), 32'(rd_div_w), 32'd24_999_999);
            chk($sformatf("mid_rst_out_ch%0d", c), 32'(out_w), 32'h0);
        end

        // Out-of-range channel select on 3-channel instance
        cyc();
        rst3 = 1'b0; en3 = 3'b001; we3 = 1'b1; ch3 = 2'd3; div3 = 8'd1;
        cyc();
        we3 = 1'b0;
        chk("oor_rd_zero", 32'(rd3_w), 32'h0);
        for (int k = 2; k <= 6; k++) begin
            cyc();
            chk($sformatf("oor_tick_k%0d", k), 32'(tick3_w[0]), 32'(k == 6));
        end
        chk("oor_rd_zero2", 32'(rd3_w), 32'h0);
        en3 = 3'b000;
        for (int c = 0; c < 3; c++) begin
            ch3 = 2'(c);
            cyc();
            chk($sformatf("oor_rd_ch%0d", c), 32'(rd3_w), 32'd5);
        end
        chk("oor_other_ticks", 32'(tick3_w), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
